// File: rtl/fifo_wr_packer.sv
// Write-domain front end of the async FIFO: packs a byte stream little-endian
// into BYTES-wide words and presents them to the FIFO through a one-word hold.
module fifo_wr_packer #(
    parameter int         BYTES = 4,
    parameter int         DSIZE = 8 * BYTES,
    parameter logic [7:0] PAD   = 8'h00,
    parameter int         CW    = 16
) (
    input  logic             wclk,
    input  logic             wrstn,
    input  logic             clr,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             wfull,
    output logic             wen,
    output logic [DSIZE-1:0] wdata,
    output logic [BYTES-1:0] wbe,
    output logic             busy,
    output logic [CW-1:0]    words_written
);

    localparam int               IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(BYTES - 1);
    localparam logic [DSIZE-1:0] PAD_WORD = {BYTES{PAD}};

    logic [DSIZE-1:0] acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DSIZE-1:0] hold_data_q, hold_data_d;
    logic [BYTES-1:0] hold_be_q, hold_be_d;
    logic             hold_vld_q, hold_vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             complete;
    logic [DSIZE-1:0] merged;
    logic [BYTES-1:0] merged_be;

    // A stuck hold blocks every byte, not just word-completing ones, so the
    // accumulator never has to absorb a byte it could not later hand off.
    assign s_ready  = ~(hold_vld_q & wfull);
    assign wen      = hold_vld_q & ~wfull;
    assign accept   = s_valid & s_ready;
    assign complete = accept & ((idx_q == LAST_IDX) | s_last);

    assign wdata         = hold_data_q;
    assign wbe           = hold_be_q;
    assign busy          = (idx_q != '0) | hold_vld_q;
    assign words_written = cnt_q;

    // Accumulator with the incoming byte dropped into lane idx; lanes above
    // idx are forced to PAD so a flushed partial word is well defined.
    always_comb begin
        merged    = acc_q;
        merged_be = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (IW'(i) == idx_q) begin
                merged[8*i +: 8] = s_data;
            end else if (IW'(i) > idx_q) begin
                merged[8*i +: 8] = PAD;
            end
            merged_be[i] = (IW'(i) <= idx_q);
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first; a path that
        // skips an assignment in always_comb would otherwise infer a latch.
        acc_d       = acc_q;
        idx_d       = idx_q;
        hold_data_d = hold_data_q;
        hold_be_d   = hold_be_q;
        hold_vld_d  = hold_vld_q;
        cnt_d       = cnt_q;

        if (wen) begin
            hold_vld_d = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A completing byte may reload the hold in the same cycle it drains,
        // which keeps back-to-back words free of bubbles.
        if (complete) begin
            hold_data_d = merged;
            hold_be_d   = merged_be;
            hold_vld_d  = 1'b1;
            idx_d       = '0;
            acc_d       = PAD_WORD;
        end else if (accept) begin
            acc_d = merged;
            idx_d = idx_q + 1'b1;
        end

        if (clr) begin
            acc_d       = PAD_WORD;
            idx_d       = '0;
            hold_data_d = '0;
            hold_be_d   = '0;
            hold_vld_d  = 1'b0;
            cnt_d       = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge. The data registers
    // are reset as well because wdata/wbe must read zero out of reset.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            acc_q       <= PAD_WORD;
            idx_q       <= '0;
            hold_data_q <= '0;
            hold_be_q   <= '0;
            hold_vld_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            hold_data_q <= hold_data_d;
            hold_be_q   <= hold_be_d;
            hold_vld_q  <= hold_vld_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: directed scenarios plus random traffic, all
// compared against a queue-based model of words formed and words drained.
module tb_fifo_wr_packer;

    localparam int         BYTES = 4;
    localparam int         DSIZE = 8 * BYTES;
    localparam logic [7:0] PAD   = 8'h00;
    localparam int         CW    = 5;
    localparam int         CMAX  = (1 << CW) - 1;

    logic             wclk = 1'b0;
    logic             wrstn = 1'b0;
    logic             clr = 1'b0;
    logic [7:0]       s_data = 8'h00;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic             wfull = 1'b0;
    logic             wen;
    logic [DSIZE-1:0] wdata;
    logic [BYTES-1:0] wbe;
    logic             busy;
    logic [CW-1:0]    words_written;

    fifo_wr_packer #(.BYTES(BYTES), .DSIZE(DSIZE), .PAD(PAD), .CW(CW)) dut (
        .wclk(wclk), .wrstn(wrstn), .clr(clr),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .wfull(wfull), .wen(wen), .wdata(wdata), .wbe(wbe),
        .busy(busy), .words_written(words_written)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: bytes of the word being built, words completed but not yet
    // accepted by the FIFO, and the saturating count of accepted words.
    logic [7:0]       part_q[$];
    logic [DSIZE-1:0] pend_data[$];
    logic [BYTES-1:0] pend_be[$];
    int               cnt_m = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        part_q.delete();
        pend_data.delete();
        pend_be.delete();
        cnt_m = 0;
    endtask

    task automatic model_form_word();
        logic [DSIZE-1:0] d;
        logic [BYTES-1:0] b;
        d = {BYTES{PAD}};
        b = '0;
        for (int i = 0; i < part_q.size(); i++) begin
            d[8*i +: 8] = part_q[i];
            b[i] = 1'b1;
        end
        pend_data.push_back(d);
        pend_be.push_back(b);
        part_q.delete();
    endtask

    // One clock: drive inputs after the falling edge, compare outputs 1 ns
    // later, then advance the model to what the next rising edge produces.
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic f, input logic c, output logic accepted);
        logic exp_ready, exp_wen;
        @(negedge wclk);
        s_valid = v; s_data = d; s_last = l; wfull = f; clr = c;
        #1;
        exp_ready = !(pend_data.size() > 0 && f);
        exp_wen   = pend_data.size() > 0 && !f;
        check("s_ready", s_ready, exp_ready);
        check("wen", wen, exp_wen);
        if (exp_wen) begin
            check("wdata", wdata, pend_data[0]);
            check("wbe", wbe, pend_be[0]);
        end
        check("busy", busy, (part_q.size() != 0) || (pend_data.size() != 0));
        check("words_written", words_written, cnt_m);
        accepted = v && exp_ready;
        if (c) begin
            model_clear();
        end else begin
            if (exp_wen) begin
                void'(pend_data.pop_front());
                void'(pend_be.pop_front());
                if (cnt_m < CMAX) cnt_m++;
            end
            if (accepted) begin
                part_q.push_back(d);
                if (part_q.size() == BYTES || l) model_form_word();
            end
        end
    endtask

    task automatic idle(input logic f);
        logic a;
        step(1'b0, 8'h00, 1'b0, f, 1'b0, a);
    endtask

    // Present one byte until taken; a stuck byte counts as a failure.
    task automatic send(input logic [7:0] d, input logic l);
        logic a;
        int   tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 20) begin
            step(1'b1, d, l, 1'b0, 1'b0, a);
            tries++;
        end
        check("send_accepted", a, 1'b1);
    endtask

    logic       acc_r;
    logic       rv, rl, rf, rc;
    logic [7:0] rd;

    initial begin
        #12 wrstn = 1'b1;

        // Reset state.
        idle(1'b0);
        check("rst_wdata", wdata, 0);
        check("rst_wbe", wbe, 0);

        // Four bytes make one full word, written the cycle after the last byte.
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        idle(1'b0);
        check("t1_wen", wen, 1);
        check("t1_wdata", wdata, 32'h44332211);
        check("t1_wbe", wbe, 4'hF);
        idle(1'b0);
        check("t1_count", words_written, 1);

        // Eight back-to-back bytes, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 0);
            if (i == 5) check("t2_word0", wdata, 32'h04030201);
        end
        idle(1'b0);
        check("t2_word1", wdata, 32'h08070605);

        // Partial words flushed by s_last.
        send(8'hAA, 0); send(8'hBB, 1);
        idle(1'b0);
        check("t3_two_data", wdata, 32'h0000BBAA);
        check("t3_two_be", wbe, 4'b0011);
        send(8'hCC, 1);
        idle(1'b0);
        check("t3_one_data", wdata, 32'h000000CC);
        check("t3_one_be", wbe, 4'b0001);

        // FIFO full: the fifth byte stalls until wfull drops.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, acc_r);
        step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0, acc_r);
        check("t4_stall_ready", s_ready, 0);
        check("t4_stall_wen", wen, 0);
        step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0, acc_r);
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, acc_r);
        check("t4_release_wen", wen, 1);
        check("t4_release_data", wdata, 32'h04030201);
        check("t4_release_acc", acc_r, 1);
        send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
        idle(1'b0);
        check("t4_next_word", wdata, 32'h08070605);

        // Synchronous clear discards a partial word.
        send(8'h61, 0); send(8'h62, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc_r);
        idle(1'b0);
        check("t5_busy", busy, 0);
        check("t5_count", words_written, 0);
        send(8'h71, 0); send(8'h72, 0); send(8'h73, 0); send(8'h74, 0);
        idle(1'b0);
        check("t5_word", wdata, 32'h74737271);

        // Counter saturation with single-byte words.
        for (int i = 0; i < CMAX + 6; i++) send(8'(i), 1);
        idle(1'b0); idle(1'b0);
        check("t6_saturated", words_written, CMAX);

        // Random traffic; the upstream holds a refused byte steady.
        acc_r = 1'b1;
        rv = 1'b0; rd = 8'h00; rl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (acc_r || !rv) begin
                rv = ($urandom % 4) != 0;
                rd = 8'($urandom);
                rl = ($urandom % 6) == 0;
            end
            rf = ($urandom % 4) == 0;
            rc = ($urandom % 250) == 0;
            step(rv, rd, rl, rf, rc, acc_r);
        end

        // Asynchronous reset mid-word.
        send(8'h91, 0); send(8'h92, 0);
        @(negedge wclk);
        s_valid = 1'b0; wfull = 1'b0;
        #2 wrstn = 1'b0;
        #1;
        check("arst_wen", wen, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", s_ready, 1);
        check("arst_wdata", wdata, 0);
        check("arst_wbe", wbe, 0);
        check("arst_count", words_written, 0);
        model_clear();
        @(posedge wclk);
        #2 wrstn = 1'b1;
        idle(1'b0); idle(1'b0);
        send(8'hE1, 1);
        idle(1'b0);
        check("arst_after_word", wdata, 32'h000000E1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
